// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: redirect kinds, privilege
// levels, fetch FSM states and the start of the privileged routine region.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    ECALL  = 2'd1,
    ERET   = 2'd2
  } redirect_kind_t;

  typedef enum logic {
    USER       = 1'b0,
    SUPERVISOR = 1'b1
  } cpl_t;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  // Fetches at or above this address are only legal in SUPERVISOR mode.
  localparam logic [63:0] PRIV_ROUTINE_START = 64'h0000_0000_0001_0000;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous instruction FIFO with flush and occupancy count.
// A push into a full queue is accepted when a pop happens in the same cycle.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            push,
  input  logic [31:0]     push_insn,
  input  logic [PC_W-1:0] push_pc,
  input  logic            pop,
  output logic [31:0]     head_insn,
  output logic [PC_W-1:0] head_pc,
  output logic            empty,
  output logic [CW-1:0]   count
);

  logic [31:0]     insn_mem [DEPTH];
  logic [PC_W-1:0] pc_mem   [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            full;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head_insn = insn_mem[rd_ptr];
  assign head_pc   = pc_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) begin
      insn_mem[wr_ptr] <= push_insn;
      pc_mem[wr_ptr]   <= push_pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential fetches, queues returned words for
// decode, handles redirects with privilege tracking and a privileged-fetch fault.
//
// state | meaning
// RUN   | fetching normally, requests may issue
// FAULT | user-mode fetch of privileged address blocked; wait for redirect
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  input  redirect_kind_t        redirect_kind_i,
  output logic                  imem_req_valid_o,
  output logic [DATA_WIDTH-1:0] imem_req_addr_o,
  input  logic                  imem_req_ready_i,
  input  logic                  imem_resp_valid_i,
  input  logic [31:0]           imem_resp_data_i,
  output logic                  insn_valid_o,
  output logic [31:0]           insn_o,
  output logic [DATA_WIDTH-1:0] insn_pc_o,
  input  logic                  insn_ready_i,
  output cpl_t                  cpl_o,
  output logic                  fault_o
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [DATA_WIDTH-1:0] PRIV_START = DATA_WIDTH'(PRIV_ROUTINE_START);

  fetch_state_t          state_q;
  fetch_state_t          state_d;
  cpl_t                  cpl_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [CW-1:0]         outstanding_q;
  logic [CW-1:0]         outstanding_d;
  logic [CW-1:0]         drop_cnt_q;
  logic [CW-1:0]         q_count;
  logic                  q_empty;
  logic                  q_push;
  logic                  q_pop;
  logic                  req_valid;
  logic                  req_hs;
  logic                  priv_fetch;
  logic                  room;

  assign priv_fetch = (cpl_q == USER) && (pc_q >= PRIV_START);
  assign room       = ({1'b0, outstanding_q} + {1'b0, q_count}) < (CW+1)'(QUEUE_DEPTH);

  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    case (state_q)
      RUN: begin
        if (!redirect_valid_i && priv_fetch) state_d = FAULT;
        // Never present a privileged address to memory, even for the one
        // cycle before the FAULT state is entered.
        req_valid = !redirect_valid_i && !priv_fetch && room;
      end
      FAULT: begin
        if (redirect_valid_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign imem_req_valid_o = req_valid && !rst;
  assign imem_req_addr_o  = pc_q;
  assign req_hs           = imem_req_valid_o && imem_req_ready_i;
  assign fault_o          = (state_q == FAULT) && !rst;
  assign cpl_o            = cpl_q;

  assign insn_valid_o  = !q_empty && !redirect_valid_i && !rst;
  assign q_pop         = insn_valid_o && insn_ready_i;
  assign q_push        = imem_resp_valid_i && (drop_cnt_q == '0) && !redirect_valid_i;
  assign outstanding_d = outstanding_q + CW'(req_hs) - CW'(imem_resp_valid_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      cpl_q         <= SUPERVISOR;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      if (redirect_valid_i) begin
        pc_q       <= redirect_pc_i;
        // Everything still in flight after this edge belongs to the old path.
        drop_cnt_q <= outstanding_d;
        case (redirect_kind_i)
          ECALL:   cpl_q <= SUPERVISOR;
          ERET:    cpl_q <= USER;
          default: cpl_q <= cpl_q;
        endcase
      end else begin
        if (req_hs) pc_q <= pc_q + DATA_WIDTH'(4);
        if (imem_resp_valid_i && (drop_cnt_q != '0)) drop_cnt_q <= drop_cnt_q - 1'b1;
      end
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .PC_W  (DATA_WIDTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid_i),
    .push      (q_push),
    .push_insn (imem_resp_data_i),
    .push_pc   (pc_q_of_resp()),
    .pop       (q_pop),
    .head_insn (insn_o),
    .head_pc   (insn_pc_o),
    .empty     (q_empty),
    .count     (q_count)
  );

  // Responses return in request order, so each response's PC is the oldest
  // outstanding request address: current PC minus four per outstanding request.
  function automatic logic [DATA_WIDTH-1:0] pc_q_of_resp();
    return pc_q - (DATA_WIDTH'(outstanding_q) << 2);
  endfunction

endmodule
